// File: rtl/router_out_arbiter.sv
// router_out_arbiter: per-output round-robin packet scheduler.
// Holds the grant for a whole frame and forwards the winner serially.
module router_out_arbiter #(
  parameter int NUM_IN  = 16,
  parameter int ID_W    = 4,
  parameter int MAX_GAP = 32,
  parameter int GAP_W   = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NUM_IN-1:0] req,
  input  logic [NUM_IN-1:0] din,
  input  logic [NUM_IN-1:0] valid_n,
  input  logic [NUM_IN-1:0] frame_n,
  output logic              dout,
  output logic              valido_n,
  output logic              frameo_n,
  output logic [NUM_IN-1:0] busy_n,
  output logic [NUM_IN-1:0] gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              gnt_vld,
  output logic              err_timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ID_W-1:0]   ptr;
  logic [ID_W-1:0]   ptr_nxt;
  logic [ID_W-1:0]   cand;
  logic [ID_W-1:0]   sel_id;
  logic [ID_W-1:0]   id_nxt;
  logic [ID_W-1:0]   id_inc;
  logic              sel_hit;
  logic              cur_din;
  logic              cur_vld_n;
  logic              cur_frm_n;
  logic              frame_end;
  logic              timeout;
  logic [GAP_W-1:0]  gap;
  logic [GAP_W-1:0]  gap_inc;
  logic [GAP_W-1:0]  gap_nxt;
  logic [NUM_IN-1:0] gnt_nxt;
  logic [NUM_IN-1:0] busy_nxt;
  logic              vld_nxt;
  logic              dout_nxt;
  logic              vo_nxt;
  logic              fo_nxt;
  logic              err_nxt;

  assign cur_din   = din[gnt_id];
  assign cur_vld_n = valid_n[gnt_id];
  assign cur_frm_n = frame_n[gnt_id];

  // pointer moves just past the released owner
  assign id_inc = (gnt_id == ID_W'(NUM_IN - 1)) ?
                  '0 : gnt_id + ID_W'(1);

  assign gap_inc = cur_vld_n ? gap + GAP_W'(1) : '0;

  // the gap that would reach the limit aborts the packet
  assign timeout = (state == XFER) &&
                   (gap_inc == GAP_W'(MAX_GAP));

  assign frame_end = (state == XFER) &&
                     !cur_vld_n && cur_frm_n;

  // round-robin pick: first requester at or after ptr
  always_comb begin
    sel_hit = 1'b0;
    sel_id  = '0;
    cand    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = ID_W'((int'(ptr) + k) % NUM_IN);
      if (!sel_hit && req[cand]) begin
        sel_hit = 1'b1;
        sel_id  = cand;
      end
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // next-state: grant on any request, release on end or abort
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sel_hit) state_nxt = XFER;
      XFER: if (timeout || frame_end) state_nxt = IDLE;
    endcase
  end

  // next values of grant, pointer, gap and forwarded pins
  always_comb begin
    gnt_nxt  = gnt;
    vld_nxt  = gnt_vld;
    id_nxt   = gnt_id;
    ptr_nxt  = ptr;
    gap_nxt  = '0;
    dout_nxt = 1'b0;
    vo_nxt   = 1'b1;
    fo_nxt   = 1'b1;
    err_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (sel_hit) begin
          gnt_nxt = NUM_IN'(1) << sel_id;
          vld_nxt = 1'b1;
          id_nxt  = sel_id;
        end
      end
      XFER: begin
        if (timeout) begin
          err_nxt = 1'b1;
          gnt_nxt = '0;
          vld_nxt = 1'b0;
          ptr_nxt = id_inc;
        end else begin
          dout_nxt = cur_din;
          vo_nxt   = cur_vld_n;
          fo_nxt   = cur_frm_n;
          gap_nxt  = gap_inc;
          if (frame_end) begin
            gnt_nxt = '0;
            vld_nxt = 1'b0;
            ptr_nxt = id_inc;
          end
        end
      end
    endcase
    busy_nxt = ~(req & ~(gnt_nxt & {NUM_IN{vld_nxt}}));
  end

  // registered outputs and datapath state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt         <= '0;
      gnt_id      <= '0;
      gnt_vld     <= 1'b0;
      busy_n      <= '1;
      dout        <= 1'b0;
      valido_n    <= 1'b1;
      frameo_n    <= 1'b1;
      err_timeout <= 1'b0;
      ptr         <= '0;
      gap         <= '0;
    end else begin
      gnt         <= gnt_nxt;
      gnt_id      <= id_nxt;
      gnt_vld     <= vld_nxt;
      busy_n      <= busy_nxt;
      dout        <= dout_nxt;
      valido_n    <= vo_nxt;
      frameo_n    <= fo_nxt;
      err_timeout <= err_nxt;
      ptr         <= ptr_nxt;
      gap         <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_router_out_arbiter.sv
// tb_router_out_arbiter: random packet senders against a
// queue-free behavioural scheduler model, plus directed cases.
module tb_router_out_arbiter;

  localparam int N    = 16;
  localparam int MAXG = 32;

  logic         clock   = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req     = '0;
  logic [N-1:0] din     = '0;
  logic [N-1:0] valid_n = '1;
  logic [N-1:0] frame_n = '1;
  logic         dout;
  logic         valido_n;
  logic         frameo_n;
  logic [N-1:0] busy_n;
  logic [N-1:0] gnt;
  logic [3:0]   gnt_id;
  logic         gnt_vld;
  logic         err_timeout;

  router_out_arbiter #(
    .NUM_IN (N),
    .ID_W   (4),
    .MAX_GAP(MAXG),
    .GAP_W  (6)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .din        (din),
    .valid_n    (valid_n),
    .frame_n    (frame_n),
    .dout       (dout),
    .valido_n   (valido_n),
    .frameo_n   (frameo_n),
    .busy_n     (busy_n),
    .gnt        (gnt),
    .gnt_id     (gnt_id),
    .gnt_vld    (gnt_vld),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  // sender state: 0 idle, 1 waiting, 2 sending, 3 release
  // pmode: 0 normal, 1 stall forever, 2 one 31-cycle gap
  int phase[N]   = '{default: 0};
  int pad[N]     = '{default: 0};
  int bits[N]    = '{default: 0};
  int gapl[N]    = '{default: 0};
  int plen[N]    = '{default: 1};
  int pmode[N]   = '{default: 0};
  int seq_req[N] = '{default: 0};
  int seq_go[N]  = '{default: 0};

  // one process drives every input port, just after each edge
  always begin
    @(posedge clock);
    #1;
    for (int i = 0; i < N; i++) begin
      if (phase[i] == 2 && !gnt[i])
        phase[i] = (pmode[i] == 1) ? 3 : 1;
      if (phase[i] == 1 && gnt[i]) begin
        phase[i] = 2;
        pad[i]   = 5;
        bits[i]  = plen[i];
        gapl[i]  = 0;
      end
      case (phase[i])
        0: begin
          req[i]     = 1'b0;
          frame_n[i] = 1'b1;
          valid_n[i] = 1'b1;
          din[i]     = 1'($urandom);
          if (seq_go[i] != seq_req[i]) begin
            seq_go[i]  = seq_go[i] + 1;
            phase[i]   = 1;
            req[i]     = 1'b1;
            frame_n[i] = 1'b0;
            valid_n[i] = 1'($urandom);
          end
        end
        1: begin
          req[i]     = 1'b1;
          frame_n[i] = 1'b0;
          valid_n[i] = 1'($urandom);
          din[i]     = 1'($urandom);
        end
        2: begin
          req[i]     = 1'b1;
          frame_n[i] = 1'b0;
          din[i]     = 1'($urandom);
          if (pad[i] > 0) begin
            valid_n[i] = 1'b1;
            pad[i]     = pad[i] - 1;
          end else if (pmode[i] == 1) begin
            valid_n[i] = 1'b1;
          end else if (gapl[i] > 0) begin
            valid_n[i] = 1'b1;
            gapl[i]    = gapl[i] - 1;
          end else begin
            valid_n[i] = 1'b0;
            bits[i]    = bits[i] - 1;
            if (bits[i] == 0) begin
              frame_n[i] = 1'b1;
              phase[i]   = 3;
            end else if (pmode[i] == 2 &&
                         bits[i] == plen[i] / 2) begin
              gapl[i] = 31;
            end else if ($urandom_range(0, 3) == 0) begin
              gapl[i] = int'($urandom_range(1, 3));
            end else begin
              gapl[i] = 0;
            end
          end
        end
        default: begin
          req[i]     = 1'b0;
          frame_n[i] = 1'b1;
          valid_n[i] = 1'b1;
          din[i]     = 1'b0;
          phase[i]   = 0;
        end
      endcase
    end
  end

  // reference: owner index (-1 = none), pointer, gap length
  int           m_owner = -1;
  int           m_ptr   = 0;
  int           m_gap   = 0;
  int           m_c;
  int           m_g;
  logic         e_dout  = 1'b0;
  logic         e_vo    = 1'b1;
  logic         e_fo    = 1'b1;
  logic         e_err   = 1'b0;
  logic [N-1:0] e_busy  = '1;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_owner = -1;
      m_ptr   = 0;
      m_gap   = 0;
      e_dout  = 1'b0;
      e_vo    = 1'b1;
      e_fo    = 1'b1;
      e_err   = 1'b0;
      e_busy  = '1;
    end else begin
      e_err  = 1'b0;
      e_dout = 1'b0;
      e_vo   = 1'b1;
      e_fo   = 1'b1;
      if (m_owner < 0) begin
        for (int k = 0; k < N; k++) begin
          m_c = (m_ptr + k) % N;
          if (req[m_c]) begin
            m_owner = m_c;
            break;
          end
        end
      end else begin
        m_g   = m_owner;
        m_gap = valid_n[m_g] ? m_gap + 1 : 0;
        if (m_gap == MAXG) begin
          e_err   = 1'b1;
          m_ptr   = (m_g + 1) % N;
          m_owner = -1;
          m_gap   = 0;
        end else begin
          e_dout = din[m_g];
          e_vo   = valid_n[m_g];
          e_fo   = frame_n[m_g];
          if (frame_n[m_g] && !valid_n[m_g]) begin
            m_ptr   = (m_g + 1) % N;
            m_owner = -1;
            m_gap   = 0;
          end
        end
      end
      for (int i = 0; i < N; i++)
        e_busy[i] = !(req[i] && m_owner != i);
    end
  end

  int           n_cmp    = 0;
  int           n_bad    = 0;
  int           n_err    = 0;
  int           glog[$];
  int           exp_q[$];
  logic         prev_vld = 1'b0;
  logic [N-1:0] eg;
  logic         seen;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (act !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // advance one cycle and compare every output with the model
  task automatic step();
    @(negedge clock);
    eg = '0;
    if (m_owner >= 0) eg[m_owner] = 1'b1;
    chk("dout", 32'(dout), 32'(e_dout));
    chk("valido_n", 32'(valido_n), 32'(e_vo));
    chk("frameo_n", 32'(frameo_n), 32'(e_fo));
    chk("err_timeout", 32'(err_timeout), 32'(e_err));
    chk("busy_n", 32'(busy_n), 32'(e_busy));
    chk("gnt", 32'(gnt), 32'(eg));
    chk("gnt_vld", 32'(gnt_vld), 32'(m_owner >= 0));
    if (m_owner >= 0)
      chk("gnt_id", 32'(gnt_id), 32'(m_owner));
    if (gnt_vld && !prev_vld) glog.push_back(int'(gnt_id));
    prev_vld = gnt_vld;
    if (err_timeout) n_err = n_err + 1;
  endtask

  function automatic bit all_quiet();
    for (int i = 0; i < N; i++)
      if (phase[i] != 0 || seq_go[i] != seq_req[i])
        return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input int budget, input string nm);
    for (int c = 0; c < budget; c++) begin
      step();
      if (m_owner < 0 && all_quiet()) return;
    end
    n_cmp = n_cmp + 1;
    n_bad = n_bad + 1;
    $display("FAIL %s: no idle after %0d cycles", nm, budget);
  endtask

  task automatic start_pkt(input int i, input int len,
                           input int mode);
    plen[i]    = len;
    pmode[i]   = mode;
    seq_req[i] = seq_req[i] + 1;
  endtask

  task automatic chk_log(input string nm);
    chk({nm, "_count"}, 32'(glog.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++)
      chk(nm, (k < glog.size()) ? 32'(glog[k]) : '1,
          32'(exp_q[k]));
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    glog.delete();
    n_err = 0;
  endtask

  initial begin
    int i;
    reset_n = 1'b0;
    step();
    step();
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_busy", 32'(busy_n), 32'hffff);
    chk("rst_vld", 32'(gnt_vld), 32'h0);
    chk("rst_frameo", 32'(frameo_n), 32'h1);
    reset_n = 1'b1;
    step();

    // single requester, then ptr=4 picks 5 before 2
    glog.delete();
    start_pkt(3, 8, 0);
    step();
    chk("lat_pre", 32'(gnt_vld), 32'h0);
    step();
    chk("lat_vld", 32'(gnt_vld), 32'h1);
    chk("lat_id", 32'(gnt_id), 32'd3);
    chk("lat_busy", 32'(busy_n), 32'hffff);
    wait_idle(300, "single");
    start_pkt(2, 3, 0);
    start_pkt(5, 3, 0);
    wait_idle(300, "after_single");
    exp_q = {3, 5, 2};
    chk_log("single_order");

    // contention from ptr=0
    do_reset();
    start_pkt(2, 6, 0);
    start_pkt(5, 6, 0);
    start_pkt(9, 6, 0);
    wait_idle(600, "contention");
    exp_q = {2, 5, 9};
    chk_log("contention_order");

    // wrap-around of the pointer
    do_reset();
    start_pkt(14, 4, 0);
    wait_idle(300, "wrap_a");
    start_pkt(0, 4, 0);
    start_pkt(15, 4, 0);
    wait_idle(300, "wrap_b");
    start_pkt(0, 3, 0);
    start_pkt(1, 3, 0);
    wait_idle(300, "wrap_c");
    exp_q = {14, 15, 0, 1, 0};
    chk_log("wrap_order");

    // gap timeout on input 7, input 10 pending
    do_reset();
    start_pkt(7, 8, 1);
    start_pkt(10, 5, 0);
    wait_idle(600, "timeout");
    exp_q = {7, 10};
    chk_log("timeout_order");
    chk("timeout_pulses", 32'(n_err), 32'd1);

    // longest tolerated gap
    do_reset();
    start_pkt(6, 8, 2);
    wait_idle(600, "gap31");
    exp_q = {6};
    chk_log("gap31_order");
    chk("gap31_pulses", 32'(n_err), 32'd0);

    // asynchronous reset in the middle of a payload
    do_reset();
    start_pkt(4, 20, 0);
    seen = 1'b0;
    for (int c = 0; c < 200 && !seen; c++) begin
      step();
      if (phase[4] == 2 && pad[4] == 0) seen = 1'b1;
    end
    chk("midrst_reached", 32'(seen), 32'h1);
    step();
    step();
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'h0);
    chk("midrst_vld", 32'(gnt_vld), 32'h0);
    chk("midrst_busy", 32'(busy_n), 32'hffff);
    chk("midrst_frameo", 32'(frameo_n), 32'h1);
    chk("midrst_valido", 32'(valido_n), 32'h1);
    chk("midrst_dout", 32'(dout), 32'h0);
    step();
    reset_n = 1'b1;
    step();
    chk("midrst_regnt_vld", 32'(gnt_vld), 32'h1);
    chk("midrst_regnt_id", 32'(gnt_id), 32'd4);
    wait_idle(600, "midrst");

    // random traffic
    do_reset();
    for (int c = 0; c < 1500; c++) begin
      step();
      if ($urandom_range(0, 5) == 0) begin
        i = int'($urandom_range(0, N - 1));
        if (phase[i] == 0 && seq_go[i] == seq_req[i])
          start_pkt(i, int'($urandom_range(1, 12)),
                    ($urandom_range(0, 9) == 0) ? 1 :
                    ($urandom_range(0, 9) == 0) ? 2 : 0);
      end
    end
    wait_idle(5000, "random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
Per-output-port scheduler for the 16-port serial packet router. One instance sits in front of each output port. It arbitrates among the input ports whose decoded destination address targets this output, using round-robin with the grant held for a whole packet. It steers the winner's serial din/valid_n/frame_n onto the output pins and drives busy_n back to the losing requesters.

Parameters:
NUM_IN, 16, number of input ports (requesters); legal range 2..16
ID_W, 4, width of grant index; must equal ceil(log2(NUM_IN))
MAX_GAP, 32, max consecutive valid_n-high cycles tolerated inside a granted packet before abort
GAP_W, 6, width of gap counter; must satisfy 2**GAP_W > MAX_GAP

Ports:
clock  input  1  system clock, all state on posedge
reset_n  input  1  asynchronous active-low reset
req  input  NUM_IN  req[i]=1: input i has a packet addressed to this output; held until its frame ends
din  input  NUM_IN  serial data from each input port
valid_n  input  NUM_IN  active-low data-valid from each input port
frame_n  input  NUM_IN  active-low frame from each input port; returns high on the last bit
dout  output  1  serial data to the output port
valido_n  output  1  active-low valid to the output port
frameo_n  output  1  active-low frame to the output port
busy_n  output  NUM_IN  busy_n[i]=0: input i is requesting and not granted
gnt  output  NUM_IN  one-hot grant; all zero when idle
gnt_id  output  ID_W  index of the granted input; valid only when gnt_vld=1
gnt_vld  output  1  a grant is active
err_timeout  output  1  one-cycle pulse when a packet is aborted on gap timeout

Behaviour:
- Reset (async, reset_n=0): state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, busy_n=all 1, dout=0, valido_n=1, frameo_n=1, err_timeout=0, rr pointer ptr=0, gap counter=0. This applies mid-packet too; the partial packet is dropped and no error pulse is issued.
- FSM has 2 states, IDLE and XFER. All outputs are registered.
- IDLE:
  - If req is nonzero, select the first i with req[i]=1 scanning ptr, ptr+1, ..., wrapping modulo NUM_IN.
  - At the next edge: gnt_vld=1, gnt=onehot(i), gnt_id=i, state=XFER.
  - Grant latency is 1 cycle from sampled req.
  - If req is zero, stay in IDLE with outputs idle (valido_n=1, frameo_n=1, dout=0).
- XFER, with g=gnt_id:
  - Every cycle: dout<=din[g], valido_n<=valid_n[g], frameo_n<=frame_n[g]. This is a 1-cycle forwarding pipeline.
  - Normal end: the cycle frame_n[g] samples 1 with valid_n[g]=0 is the last bit. It is forwarded normally. At the same edge: gnt=0, gnt_vld=0, ptr<=(g+1) mod NUM_IN, state=IDLE.
  - The next arbitration occurs in IDLE. Back-to-back packets are therefore separated by at least 1 idle output cycle with frameo_n=1.
  - Gap counter: increments each XFER cycle with valid_n[g]=1, clears when valid_n[g]=0. It covers the 5-cycle address-padding gap and inter-bit gaps.
  - Timeout: when the counter reaches MAX_GAP, abort. frameo_n<=1, valido_n<=1, dout<=0, err_timeout=1 for 1 cycle, ptr<=(g+1) mod NUM_IN, state=IDLE.
  - Timeout takes precedence if it coincides with frame end.
  - req[g] is ignored during XFER; only frame end or timeout releases the grant.
- busy_n, registered each cycle: busy_n[i] = ~(req[i] & ~(gnt_vld_next & gnt_next[i])). The granted input sees busy_n=1 from the cycle its grant appears.
- Simultaneous requests are always resolved by ptr; no input is starved for more than NUM_IN-1 packets.
- ptr wraps from NUM_IN-1 to 0.
- New requests arriving during XFER only raise busy_n; they are arbitrated after release.
- frame_n/valid_n/din of non-granted inputs never affect outputs.

Test Plan:
- Single requester: reset, req[3]=1, 8-bit packet on input 3 → gnt_id=3, gnt_vld=1 one cycle after req; dout matches din[3] delayed 1 cycle; frameo_n rises with the last bit; ptr becomes 4; busy_n stays all 1.
- Contention: req[2], req[5] and req[9] rise on the same cycle with ptr=0 → grants in order 2, 5, 9. Losers see busy_n=0 until granted, and exactly 1 idle cycle falls between packets.
- Wrap-around: force ptr=15 by completing a packet from input 14, then raise req[0] and req[15] together → 15 granted first, then 0; ptr ends at 1.
- Timeout: grant input 7, then hold valid_n[7]=1 and frame_n[7]=0 for MAX_GAP=32 cycles → err_timeout pulses once, frameo_n=1, gnt_vld=0, and the next pending requester is granted.
- Reset mid-packet: assert reset_n=0 asynchronously mid-payload of input 4 → all outputs return to reset values immediately with no clock edge; after release with req[4] still high, a fresh grant to 4 follows 1 cycle later (ptr=0).
- Gap tolerance: a packet with a 5-cycle padding gap and one 31-cycle inter-bit gap completes normally with no err_timeout.
